// File: rtl/mac_vector_feeder_if.sv
// Operand/result bus between mac_vector_feeder (master) and one pipelined
// saturating MAC (slave).
interface mac_vector_feeder_if #(
   parameter int WIDTH = 14,
   parameter int ACC_W = 28
);
   logic             mac_reset;
   logic [WIDTH-1:0] mac_a;
   logic [WIDTH-1:0] mac_b;
   logic             mac_valid_in;
   logic [ACC_W-1:0] mac_f;
   logic             mac_valid_out;

   modport master (
      output mac_reset, mac_a, mac_b, mac_valid_in,
      input  mac_f, mac_valid_out
   );

   modport slave (
      input  mac_reset, mac_a, mac_b, mac_valid_in,
      output mac_f, mac_valid_out
   );
endinterface

// File: rtl/mac_vector_feeder.sv
// Drives one pipelined MAC with a len-element dot product held in two
// host-written operand buffers, then captures the final accumulator value.
module mac_vector_feeder #(
   parameter int WIDTH    = 14,
   parameter int ACC_W    = 28,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int CLR_WAIT = 5,
   parameter int MAC_LAT  = 5,
   parameter int TO_SLACK = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [WIDTH-1:0]    wr_a,
   input  logic [WIDTH-1:0]    wr_b,
   input  logic                start,
   input  logic [ADDR_W:0]     len,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [ACC_W-1:0]    result,
   mac_vector_feeder_if.master mac
);

   localparam int CNT_W  = ADDR_W + 1;
   localparam int WAIT_W = (CLR_WAIT < 2) ? 1 : $clog2(CLR_WAIT + 1);
   localparam int DRN_W  = $clog2(MAC_LAT + TO_SLACK + 1);

   localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(CLR_WAIT - 1);
   localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(MAC_LAT + TO_SLACK - 1);
   localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_STREAM = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_FINISH = 3'd5
   } state_t;

   state_t            state_r;
   state_t            state_nx_s;

   logic [WIDTH-1:0]  buf_a_r [DEPTH];
   logic [WIDTH-1:0]  buf_b_r [DEPTH];

   logic [CNT_W-1:0]  len_r;
   logic [CNT_W-1:0]  out_cnt_r;
   logic [ADDR_W-1:0] rd_idx_r;
   logic [WAIT_W-1:0] wait_cnt_r;
   logic [DRN_W-1:0]  drain_cnt_r;

   logic              busy_r;
   logic              done_r;
   logic              error_r;
   logic [ACC_W-1:0]  result_r;
   logic              mac_reset_r;
   logic [WIDTH-1:0]  mac_a_r;
   logic [WIDTH-1:0]  mac_b_r;
   logic              mac_valid_in_r;

   logic [CNT_W-1:0]  len_clip_s;
   logic [CNT_W-1:0]  last_idx_s;
   logic [ADDR_W-1:0] rd_idx_nx_s;
   logic              count_s;
   logic              capture_s;
   logic              final_beat_s;
   logic              timeout_s;
   logic              accept_s;

   // Run-control decodes shared by the FSM and the datapath registers.
   always_comb begin
      len_clip_s   = (len > DEPTH_C) ? DEPTH_C : len;
      last_idx_s   = len_r - CNT_W'(1);
      accept_s     = (state_r == ST_IDLE) && start;
      count_s      = mac.mac_valid_out &&
                     ((state_r == ST_STREAM) || (state_r == ST_DRAIN));
      capture_s    = count_s && (out_cnt_r == last_idx_s);
      final_beat_s = ({1'b0, rd_idx_r} == last_idx_s);
      timeout_s    = (drain_cnt_r == DRAIN_LAST);
   end

   // Next-state and next read index.
   always_comb begin
      state_nx_s  = state_r;
      rd_idx_nx_s = rd_idx_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nx_s = (len_clip_s == '0) ? ST_FINISH : ST_CLEAR;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            state_nx_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_cnt_r == WAIT_LAST) begin
               state_nx_s  = ST_STREAM;
               rd_idx_nx_s = '0;
            end else begin
               state_nx_s = ST_WAIT;
            end
         end
         ST_STREAM: begin
            // An early final valid_out can only come from a misbehaving MAC;
            // it still ends the run so the host is never left hanging.
            if (capture_s) begin
               state_nx_s = ST_FINISH;
            end else if (final_beat_s) begin
               state_nx_s = ST_DRAIN;
            end else begin
               rd_idx_nx_s = rd_idx_r + ADDR_W'(1);
            end
         end
         ST_DRAIN: begin
            if (capture_s || timeout_s) begin
               state_nx_s = ST_FINISH;
            end else begin
               state_nx_s = ST_DRAIN;
            end
         end
         ST_FINISH: begin
            state_nx_s = ST_IDLE;
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Host write port into the operand buffers; writes are only taken in IDLE.
   always_ff @(posedge clk) begin
      if (wr_en && (state_r == ST_IDLE)) begin
         buf_a_r[wr_addr] <= wr_a;
         buf_b_r[wr_addr] <= wr_b;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= ST_IDLE;
         len_r          <= '0;
         out_cnt_r      <= '0;
         rd_idx_r       <= '0;
         wait_cnt_r     <= '0;
         drain_cnt_r    <= '0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         error_r        <= 1'b0;
         result_r       <= '0;
         mac_reset_r    <= 1'b1;
         mac_a_r        <= '0;
         mac_b_r        <= '0;
         mac_valid_in_r <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         rd_idx_r    <= rd_idx_nx_s;
         wait_cnt_r  <= (state_r == ST_WAIT)  ? wait_cnt_r + WAIT_W'(1) : '0;
         drain_cnt_r <= (state_r == ST_DRAIN) ? drain_cnt_r + DRN_W'(1) : '0;
         done_r      <= (state_r == ST_FINISH);

         // MAC-side outputs are loaded from the next state so they line up
         // with the CLEAR and STREAM cycles themselves.
         mac_reset_r    <= (state_nx_s == ST_CLEAR);
         mac_valid_in_r <= (state_nx_s == ST_STREAM);
         if (state_nx_s == ST_STREAM) begin
            mac_a_r <= buf_a_r[rd_idx_nx_s];
            mac_b_r <= buf_b_r[rd_idx_nx_s];
         end else begin
            mac_a_r <= '0;
            mac_b_r <= '0;
         end

         if (accept_s) begin
            len_r     <= len_clip_s;
            out_cnt_r <= '0;
            busy_r    <= 1'b1;
            error_r   <= 1'b0;
            result_r  <= '0;
         end else begin
            if (state_r == ST_FINISH) begin
               busy_r <= 1'b0;
            end
            if (count_s) begin
               out_cnt_r <= out_cnt_r + CNT_W'(1);
            end
            if (capture_s) begin
               result_r <= mac.mac_f;
            end
            if ((state_r == ST_DRAIN) && timeout_s && !capture_s) begin
               error_r <= 1'b1;
            end
         end
      end
   end

   assign busy             = busy_r;
   assign done             = done_r;
   assign error            = error_r;
   assign result           = result_r;
   assign mac.mac_reset    = mac_reset_r;
   assign mac.mac_a        = mac_a_r;
   assign mac.mac_b        = mac_b_r;
   assign mac.mac_valid_in = mac_valid_in_r;

endmodule

// File: tb/tb_mac_vector_feeder.sv
// Randomised bench for mac_vector_feeder: a behavioural saturating MAC drives
// the slave side and each run is checked against a dot-product reference.
module tb_mac_vector_feeder;
   localparam int WIDTH    = 14;
   localparam int ACC_W    = 28;
   localparam int DEPTH    = 16;
   localparam int ADDR_W   = 4;
   localparam int CLR_WAIT = 5;
   localparam int MAC_LAT  = 5;
   localparam int TO_SLACK = 8;
   localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
   localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              wr_en = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [WIDTH-1:0]  wr_a = '0;
   logic [WIDTH-1:0]  wr_b = '0;
   logic              start = 1'b0;
   logic [ADDR_W:0]   len = '0;
   logic              busy, done, error;
   logic [ACC_W-1:0]  result;

   mac_vector_feeder_if #(.WIDTH(WIDTH), .ACC_W(ACC_W)) mif ();

   mac_vector_feeder #(
      .WIDTH(WIDTH), .ACC_W(ACC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
      .CLR_WAIT(CLR_WAIT), .MAC_LAT(MAC_LAT), .TO_SLACK(TO_SLACK)
   ) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_a(wr_a), .wr_b(wr_b), .start(start), .len(len),
      .busy(busy), .done(done), .error(error), .result(result),
      .mac(mif)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint sat(input longint v);
      if (v > ACC_MAX) return ACC_MAX;
      if (v < ACC_MIN) return ACC_MIN;
      return v;
   endfunction

   // Behavioural MAC: product pipeline of MAC_LAT stages, saturating accumulate.
   logic [MAC_LAT-2:0] pv = '0;
   longint             pp [MAC_LAT-1];
   longint             acc = 0;
   logic               vout = 1'b0;
   logic               mac_hold = 1'b0;
   logic               stray = 1'b0;

   always @(posedge clk) begin
      if (mif.mac_reset) begin
         pv   <= '0;
         acc  <= 0;
         vout <= 1'b0;
      end else begin
         pv <= {pv[MAC_LAT-3:0], mif.mac_valid_in};
         for (int i = MAC_LAT - 2; i > 0; i--) pp[i] <= pp[i-1];
         pp[0] <= longint'($signed(mif.mac_a)) * longint'($signed(mif.mac_b));
         if (pv[MAC_LAT-2]) begin
            acc  <= sat(acc + pp[MAC_LAT-2]);
            vout <= !mac_hold;
         end else begin
            vout <= 1'b0;
         end
      end
   end

   assign mif.mac_f         = acc[ACC_W-1:0];
   assign mif.mac_valid_out = vout | stray;

   // Cycle count and bus monitor.
   int     cyc = 0;
   int     done_cnt = 0;
   int     rst_cnt = 0;
   int     rst_cyc = 0;
   int     vin_first = 0;
   int     vin_last = 0;
   longint beat_a[$];
   longint beat_b[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (busy && mif.mac_reset) begin
         rst_cnt++;
         rst_cyc = cyc;
      end
      if (mif.mac_valid_in) begin
         if (beat_a.size() == 0) vin_first = cyc;
         vin_last = cyc;
         beat_a.push_back(longint'($signed(mif.mac_a)));
         beat_b.push_back(longint'($signed(mif.mac_b)));
      end
   end

   longint ref_a [DEPTH];
   longint ref_b [DEPTH];

   task automatic wr(input int addr, input int a, input int b);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(addr);
      wr_a    = WIDTH'(a);
      wr_b    = WIDTH'(b);
      ref_a[addr] = longint'($signed(wr_a));
      ref_b[addr] = longint'($signed(wr_b));
      @(posedge clk);
      #1 wr_en = 1'b0;
   endtask

   task automatic run(input int l, input bit hold, input bit stray_en, output longint res);
      int     n;
      longint exp_res;
      bit     got;
      int     t0;
      int     td;
      n = (l > DEPTH) ? DEPTH : l;
      exp_res = 0;
      for (int i = 0; i < n; i++) exp_res = sat(exp_res + ref_a[i] * ref_b[i]);
      if (hold) exp_res = 0;
      mac_hold = hold;
      @(negedge clk);
      rst_cnt = 0;
      beat_a.delete();
      beat_b.delete();
      start = 1'b1;
      len   = (ADDR_W+1)'(l);
      t0    = cyc;
      got   = 1'b0;
      td    = 0;
      for (int k = 1; k <= 400 && !got; k++) begin
         @(negedge clk);
         start   = 1'b0;
         wr_en   = (k == 1);
         wr_addr = ADDR_W'($urandom);
         wr_a    = WIDTH'($urandom);
         wr_b    = WIDTH'($urandom);
         stray   = stray_en && (k == 3);
         if (k == 1) check("busy_after_start", longint'(busy), 1);
         if (done) begin
            got = 1'b1;
            td  = cyc;
         end
      end
      wr_en = 1'b0;
      stray = 1'b0;
      check("done_seen", longint'(got), 1);
      res = longint'($signed(result));
      check("result", res, exp_res);
      check("error", longint'(error), longint'(hold));
      check("busy_at_done", longint'(busy), 0);
      check("beat_count", beat_a.size(), n);
      for (int i = 0; i < n && i < beat_a.size(); i++) begin
         check("beat_a", beat_a[i], ref_a[i]);
         check("beat_b", beat_b[i], ref_b[i]);
      end
      if (n == 0) begin
         check("mac_reset_cnt", rst_cnt, 0);
         check("len0_latency", td - t0, 2);
      end else begin
         check("mac_reset_cnt", rst_cnt, 1);
         check("clear_to_stream", vin_first - rst_cyc, CLR_WAIT + 1);
         check("stream_contig", vin_last - vin_first + 1, n);
         check("drain_latency", td - vin_last, hold ? (MAC_LAT + TO_SLACK + 2) : (MAC_LAT + 2));
      end
      @(negedge clk);
      check("done_pulse", longint'(done), 0);
      mac_hold = 1'b0;
   endtask

   initial begin
      longint res;
      bit     seen;
      int     d0;

      repeat (3) @(negedge clk);
      check("rst_busy", longint'(busy), 0);
      check("rst_done", longint'(done), 0);
      check("rst_error", longint'(error), 0);
      check("rst_result", longint'(result), 0);
      check("rst_valid_in", longint'(mif.mac_valid_in), 0);
      check("rst_mac_a", longint'(mif.mac_a), 0);
      check("rst_mac_b", longint'(mif.mac_b), 0);
      check("rst_mac_reset", longint'(mif.mac_reset), 1);
      reset = 1'b0;

      wr(0, 1, 4); wr(1, 2, 5); wr(2, 3, 6);
      run(3, 1'b0, 1'b0, res);
      check("tp_dot3", res, 32);

      for (int i = 0; i < DEPTH; i++) wr(i, 8191, 8191);
      run(16, 1'b0, 1'b0, res);
      check("tp_sat_pos", res, 134217727);

      for (int i = 0; i < 4; i++) wr(i, -8192, 8191);
      run(4, 1'b0, 1'b0, res);
      check("tp_sat_neg", res, -134217728);

      run(0, 1'b0, 1'b0, res);
      check("tp_len0", res, 0);

      run(3, 1'b1, 1'b0, res);
      check("tp_timeout_result", res, 0);

      for (int i = 0; i < DEPTH; i++) wr(i, int'($urandom), int'($urandom));
      run(20, 1'b0, 1'b0, res);

      wr(0, 100, -7);
      run(1, 1'b0, 1'b1, res);
      check("tp_stray_ignored", res, -700);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < DEPTH; i++) begin
            if ($urandom_range(0, 1) == 1) wr(i, int'($urandom), int'($urandom));
         end
         run(int'($urandom_range(0, 20)), 1'b0, 1'b0, res);
      end

      for (int i = 0; i < DEPTH; i++) wr(i, int'($urandom), int'($urandom));
      @(negedge clk);
      start = 1'b1;
      len   = 5'd16;
      @(negedge clk);
      start = 1'b0;
      seen  = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(negedge clk);
         if (mif.mac_valid_in) seen = 1'b1;
      end
      check("abort_stream_seen", longint'(seen), 1);
      d0 = done_cnt;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_busy", longint'(busy), 0);
      check("abort_valid_in", longint'(mif.mac_valid_in), 0);
      check("abort_mac_reset", longint'(mif.mac_reset), 1);
      check("abort_mac_a", longint'(mif.mac_a), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_idle", longint'(busy), 0);

      wr(0, -3, 5); wr(1, 7, 2);
      run(2, 1'b0, 1'b0, res);
      check("tp_reset_rerun", res, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
